// File: rtl/micro86_bus_pkg.sv
// micro86_bus_pkg: declarations shared by the micro86 memory front end.
//   state_t        - FSM state encoding (IDLE=0, FILL=1, WRITE=2, DONE=3)
//   LINE_BYTES_DEF - default line size in bytes
//   ADDR_W_DEF     - default physical address width
//   off_w()        - byte-offset width derived from the line size
package micro86_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LINE_BYTES_DEF = 4;
  localparam int ADDR_W_DEF     = 20;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/micro86_bus_line.sv
// micro86_bus_line: single aligned read line.
//   clock/reset   - system clock, async active-high reset (clears valid only)
//   rd_addr_i     - core address; hit_o / rd_data_o are combinational from it
//   inv_i         - clear valid at the edge (wins over set_valid_i)
//   set_valid_i   - mark the line valid at the edge
//   tag_ld_i/tag_i- load a new tag at the edge
//   wr_en_i       - write wr_data_i into byte wr_addr_i[OFF_W-1:0]
//   wr_chk_i      - when set, the write only lands if the line is valid and
//                   wr_addr_i's tag matches (write-through update)
import micro86_bus_pkg::*;

module micro86_bus_line #(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  localparam int OFF_W     = off_w(LINE_BYTES),
  localparam int TAG_W     = ADDR_W - OFF_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              hit_o,
  output logic [7:0]        rd_data_o,
  input  logic              inv_i,
  input  logic              set_valid_i,
  input  logic              tag_ld_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              wr_en_i,
  input  logic              wr_chk_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       bytes_q [LINE_BYTES];
  logic             wr_do;

  assign hit_o     = valid_q && (rd_addr_i[ADDR_W-1:OFF_W] == tag_q);
  assign rd_data_o = bytes_q[rd_addr_i[OFF_W-1:0]];

  // Fill writes land unconditionally; store updates only touch a matching line.
  assign wr_do = wr_en_i && (!wr_chk_i || (valid_q && (wr_addr_i[ADDR_W-1:OFF_W] == tag_q)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            valid_q <= 1'b0;
    else if (inv_i)       valid_q <= 1'b0;
    else if (set_valid_i) valid_q <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (tag_ld_i) tag_q <= tag_i;
    if (wr_do)    bytes_q[wr_addr_i[OFF_W-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/micro86_bus.sv
// micro86_bus: byte-wide memory front end for the micro86 core.
//   clock, reset        - system clock, async active-high reset
//   cpu_a/cpu_o/cpu_w   - core address, write data, write strobe
//   cpu_i/cpu_ce        - combinational read data and clock-enable (0 = stall)
//   flush               - invalidate the read line
//   mem_addr/mem_wdata/mem_we/mem_req - registered external request
//   mem_ack/mem_rdata   - single-cycle completion and read data
// Reads hit a single aligned line with no wait states; misses fill the whole
// line beat by beat; every store is written through to external memory.
import micro86_bus_pkg::*;

module micro86_bus #(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [7:0]        cpu_o,
  input  logic              cpu_w,
  output logic [7:0]        cpu_i,
  output logic              cpu_ce,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  localparam int OFF_W = off_w(LINE_BYTES);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_BYTES - 1);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              fpend_q, fpend_d;

  logic              hit;
  logic              ce_c;
  logic              ln_inv, ln_set, ln_tag_ld, ln_wr_en, ln_wr_chk;
  logic [7:0]        ln_wr_data;

  micro86_bus_line #(
    .LINE_BYTES (LINE_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_line (
    .clock       (clock),
    .reset       (reset),
    .rd_addr_i   (cpu_a),
    .hit_o       (hit),
    .rd_data_o   (cpu_i),
    .inv_i       (ln_inv),
    .set_valid_i (ln_set),
    .tag_ld_i    (ln_tag_ld),
    .tag_i       (cpu_a[ADDR_W-1:OFF_W]),
    .wr_en_i     (ln_wr_en),
    .wr_chk_i    (ln_wr_chk),
    .wr_addr_i   (addr_q),
    .wr_data_i   (ln_wr_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      fpend_q <= fpend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    beat_d     = beat_q;
    fpend_d    = fpend_q;
    ce_c       = 1'b0;
    ln_inv     = 1'b0;
    ln_set     = 1'b0;
    ln_tag_ld  = 1'b0;
    ln_wr_en   = 1'b0;
    ln_wr_chk  = 1'b0;
    ln_wr_data = mem_rdata;

    case (state_q)
      ST_IDLE: begin
        ln_inv = flush;
        if (cpu_w) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = cpu_a;
          wdata_d = cpu_o;
          state_d = ST_WRITE;
        end else if (hit) begin
          ce_c = 1'b1;
        end else begin
          ln_inv    = 1'b1;
          ln_tag_ld = 1'b1;
          req_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = {cpu_a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          beat_d    = '0;
          fpend_d   = 1'b0;
          state_d   = ST_FILL;
        end
      end

      ST_FILL: begin
        // A flush cannot drop the line mid-fill; it is remembered and
        // applied when the last beat lands.
        fpend_d = fpend_q | flush;
        if (mem_ack) begin
          ln_wr_en = 1'b1;
          beat_d   = beat_q + 1'b1;
          addr_d   = addr_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            req_d   = 1'b0;
            ln_set  = !(fpend_q | flush);
            fpend_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        ln_inv = flush;
        if (mem_ack) begin
          req_d      = 1'b0;
          we_d       = 1'b0;
          ln_wr_en   = 1'b1;
          ln_wr_chk  = 1'b1;
          ln_wr_data = wdata_q;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        ce_c    = 1'b1;
        ln_inv  = flush;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Stall the core immediately while reset is held, independent of state.
  assign cpu_ce    = ce_c & ~reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_req   = req_q;

endmodule

// File: tb/tb_micro86_bus.sv
module tb_micro86_bus;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] cpu_a = '0;
  logic [7:0]  cpu_o = '0;
  logic        cpu_w = 1'b0;
  logic [7:0]  cpu_i;
  logic        cpu_ce;
  logic        flush = 1'b0;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  micro86_bus #(.LINE_BYTES(4), .ADDR_W(20)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_a     (cpu_a),
    .cpu_o     (cpu_o),
    .cpu_w     (cpu_w),
    .cpu_i     (cpu_i),
    .cpu_ce    (cpu_ce),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  // External memory: 4 KiB image indexed by the low address bits, ack after
  // ack_delay wait cycles per request beat.
  logic [7:0]  mem [0:4095];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [19:0] log_addr [$];
  logic        log_we   [$];
  logic [7:0]  log_wd   [$];

  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem[mem_addr[11:0]];

  always @(posedge clock) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_ack) begin
      log_addr.push_back(mem_addr);
      log_we.push_back(mem_we);
      log_wd.push_back(mem_wdata);
      if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    end
  end

  // Request stability: while a request waits for ack, address/we/data hold.
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [19:0] prev_addr = '0;
  logic [7:0]  prev_wd = '0;
  int          unstable = 0;
  int          held = 0;

  always @(posedge clock) begin
    if (mem_req && prev_req && !prev_ack) begin
      held <= held + 1;
      if (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wd)
        unstable <= unstable + 1;
    end
    prev_req  <= mem_req;
    prev_ack  <= mem_ack;
    prev_addr <= mem_addr;
    prev_we   <= mem_we;
    prev_wd   <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wd.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the retiring edge.
  task automatic cpu_read(input logic [19:0] a, output logic [7:0] d, output int stalls);
    cpu_a  = a;
    cpu_w  = 1'b0;
    stalls = 0;
    d      = 'x;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (cpu_ce) begin
        d = cpu_i;
        @(posedge clock); #1;
        return;
      end
      stalls++;
      @(posedge clock); #1;
    end
    check("read_timeout", 32'(stalls), 32'(0));
  endtask

  task automatic cpu_write(input logic [19:0] a, input logic [7:0] v, output int stalls);
    cpu_a  = a;
    cpu_o  = v;
    cpu_w  = 1'b1;
    stalls = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (cpu_ce) begin
        @(posedge clock); #1;
        cpu_w = 1'b0;
        return;
      end
      stalls++;
      @(posedge clock); #1;
    end
    cpu_w = 1'b0;
    check("write_timeout", 32'(stalls), 32'(0));
  endtask

  logic [7:0] d;
  int         st;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5C;
    mem[12'h100] = 8'h11;
    mem[12'h101] = 8'h22;
    mem[12'h102] = 8'h33;
    mem[12'h103] = 8'h44;
    mem[12'hFFF] = 8'h77;

    // Reset state
    #2;
    check("rst_req",   32'(mem_req),   32'h0);
    check("rst_we",    32'(mem_we),    32'h0);
    check("rst_addr",  32'(mem_addr),  32'h0);
    check("rst_wdata", 32'(mem_wdata), 32'h0);
    check("rst_ce",    32'(cpu_ce),    32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Cold read
    clear_log();
    cpu_read(20'h00102, d, st);
    check("cold_data",   32'(d),  32'h33);
    check("cold_stalls", 32'(st), 32'd5);
    check("cold_beats",  32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < log_addr.size()) check("cold_addr", 32'(log_addr[i]), 32'h100 + 32'(i));
    cpu_read(20'h00103, d, st);
    check("hit_data",   32'(d),  32'h44);
    check("hit_stalls", 32'(st), 32'd0);

    // Write hit
    clear_log();
    cpu_write(20'h00101, 8'hA5, st);
    check("wr_stalls", 32'(st), 32'd2);
    check("wr_reqs",   32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      check("wr_addr", 32'(log_addr[0]), 32'h101);
      check("wr_we",   32'(log_we[0]),   32'h1);
      check("wr_data", 32'(log_wd[0]),   32'hA5);
    end
    cpu_read(20'h00101, d, st);
    check("wrhit_data",   32'(d),  32'hA5);
    check("wrhit_stalls", 32'(st), 32'd0);
    check("wrhit_mem",    32'(mem[12'h101]), 32'hA5);

    // Write miss: no allocate, old line still valid
    cpu_write(20'h20000, 8'h5A, st);
    check("wrmiss_stalls", 32'(st), 32'd2);
    cpu_read(20'h00100, d, st);
    check("wrmiss_data",   32'(d),  32'h11);
    check("wrmiss_stalls2", 32'(st), 32'd0);

    // Wait states
    ack_delay = 3;
    cpu_read(20'h00206, d, st);
    check("wait_stalls", 32'(st), 32'd17);
    check("wait_data",   32'(d),  32'h5A);
    check("wait_unstable", 32'(unstable), 32'd0);
    check("wait_held_seen", 32'(held >= 12), 32'd1);
    ack_delay = 0;

    // Flush during fill beat 2
    clear_log();
    cpu_a = 20'h00300;
    cpu_w = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    @(posedge clock); #1;
    #1;
    check("flush_fill_beats", 32'(log_addr.size()), 32'd4);
    check("flush_ce", 32'(cpu_ce), 32'h0);
    clear_log();
    cpu_read(20'h00300, d, st);
    check("flush_refill_stalls", 32'(st), 32'd5);
    check("flush_refill_beats",  32'(log_addr.size()), 32'd4);
    check("flush_refill_data",   32'(d), 32'h5C);

    // Reset mid-fill
    cpu_a = 20'h00400;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("rstfill_req", 32'(mem_req), 32'h0);
    check("rstfill_ce",  32'(cpu_ce),  32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    cpu_read(20'h00100, d, st);
    check("rstfill_miss_stalls", 32'(st), 32'd5);
    check("rstfill_data",        32'(d),  32'h11);

    // Flush in the same cycle as a hit
    cpu_a = 20'h00101;
    flush = 1'b1;
    #1;
    check("flushhit_ce",   32'(cpu_ce), 32'h1);
    check("flushhit_data", 32'(cpu_i),  32'hA5);
    @(posedge clock); #1;
    flush = 1'b0;
    cpu_read(20'h00101, d, st);
    check("flushhit_next_stalls", 32'(st), 32'd5);
    check("flushhit_next_data",   32'(d),  32'hA5);

    // Top-of-memory line, no wrap
    clear_log();
    cpu_read(20'hFFFFF, d, st);
    check("top_data",   32'(d),  32'h77);
    check("top_stalls", 32'(st), 32'd5);
    check("top_beats",  32'(log_addr.size()), 32'd4);
    if (log_addr.size() == 4) begin
      check("top_first", 32'(log_addr[0]), 32'hFFFFC);
      check("top_last",  32'(log_addr[3]), 32'hFFFFF);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
